// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch front end: drives imem, captures its registered read data and
// hands {pc, instruction} pairs to decode through a 2-entry queue, with redirect flush.
module fetch_stage #(
  parameter int unsigned       LENGTH   = 32,
  parameter int unsigned       SIZE     = 1024,
  parameter int unsigned       SEL_BITS = $clog2(SIZE),
  parameter logic [LENGTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [SEL_BITS-1:0] imem_addr,
  input  logic [LENGTH-1:0]   imem_ins,
  input  logic                redirect_valid,
  input  logic [LENGTH-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LENGTH-1:0]   out_pc,
  output logic [LENGTH-1:0]   out_ins
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef struct packed {
    logic [LENGTH-1:0] pc;
    logic [LENGTH-1:0] ins;
  } entry_t;

  logic [LENGTH-1:0] fpc;
  logic              inflight;
  logic [LENGTH-1:0] inflight_pc;
  entry_t            queue [DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              deq;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occupancy;
  logic [LENGTH-1:0] redirect_base;
  logic [LENGTH-1:0] fetch_pc;
  logic              unused_bits;

  // Handshake, issue throttle and fetch address selection
  always_comb begin
    out_valid     = (count != '0) & ~redirect_valid;
    out_pc        = '0;
    out_ins       = '0;
    if (count != '0) begin
      out_pc  = queue[rd_ptr].pc;
      out_ins = queue[rd_ptr].ins;
    end
    deq           = out_valid & out_ready;
    push          = inflight & ~redirect_valid;
    // A read issued now returns next cycle; only issue if a slot will be free for it.
    occupancy     = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(deq);
    issue         = occupancy < OCC_W'(2);
    redirect_base = {redirect_pc[LENGTH-1:2], 2'b00};
    fetch_pc      = redirect_valid ? redirect_base : fpc;
    imem_addr     = fetch_pc[SEL_BITS+1:2];
  end

  assign unused_bits = ^{redirect_pc[1:0], fetch_pc[1:0], fetch_pc[LENGTH-1:SEL_BITS+2]};

  // Fetch pointer, outstanding read tracking and output queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        queue[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush everything; the outstanding read is dropped and the target is fetched now.
      fpc         <= redirect_base + LENGTH'(4);
      inflight    <= 1'b1;
      inflight_pc <= redirect_base;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fpc;
        fpc         <= fpc + LENGTH'(4);
      end
      if (push) begin
        queue[wr_ptr] <= '{pc: inflight_pc, ins: imem_ins};
        wr_ptr        <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + CNT_W'(push) - CNT_W'(deq);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for fetch_stage: a pc-stream model predicts every accepted pair.
module tb_fetch_stage;

  localparam int unsigned LENGTH   = 32;
  localparam int unsigned SIZE     = 1024;
  localparam int unsigned SB       = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic [SB-1:0] imem_addr;
  logic [31:0]   imem_ins;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_ins;

  logic [31:0] mem [SIZE];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] nxt_pc;
  int          since;

  fetch_stage #(
    .LENGTH(LENGTH), .SIZE(SIZE), .SEL_BITS(SB), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_ins(imem_ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous imem
  always @(posedge clk) imem_ins <= mem[imem_addr];

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the cycle in which pc is seen at the head.
  task automatic wait_head(input logic [31:0] pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == pc) found = 1'b1;
      tick();
    end
    check(found, "wait_head", 32'(found), 32'd1);
  endtask

  // Monitor: handshake scoreboard, valid timing and redirect address checks
  initial begin
    exp_t e;
    logic [31:0] w;
    nxt_pc = RESET_PC;
    since  = -1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check(out_valid == 1'b0, "rst_valid", 32'(out_valid), 32'd0);
        check(out_pc == 32'd0, "rst_pc", out_pc, 32'd0);
        check(out_ins == 32'd0, "rst_ins", out_ins, 32'd0);
        exp_q.delete();
        nxt_pc = RESET_PC;
        since  = -1;
      end else begin
        if (since < 100) since++;
        check(out_valid == (!redirect_valid && since >= 2), "valid_timing",
              32'(out_valid), 32'(!redirect_valid && since >= 2));
        if (dut.push && dut.count == 2'd2 && !dut.deq)
          check(1'b0, "push_full", 32'(dut.count), 32'd1);
        if (!out_valid && !redirect_valid) begin
          check(out_pc == 32'd0, "idle_pc", out_pc, 32'd0);
          check(out_ins == 32'd0, "idle_ins", out_ins, 32'd0);
        end
        if (redirect_valid) begin
          w = 32'(redirect_pc[SB+1:2]);
          check(32'(imem_addr) == w, "redirect_addr", 32'(imem_addr), w);
          exp_q.delete();
          nxt_pc = {redirect_pc[31:2], 2'b00};
          since  = 0;
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back('{pc: nxt_pc, ins: mem[nxt_pc[SB+1:2]]});
            nxt_pc = nxt_pc + 32'd4;
          end
          e = exp_q.pop_front();
          check(out_pc == e.pc, "sb_pc", out_pc, e.pc);
          check(out_ins == e.ins, "sb_ins", out_ins, e.ins);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] wrap_addr [5];
    wrap_addr = '{32'd1022, 32'd1023, 32'd0, 32'd1, 32'd2};
    for (int k = 0; k < int'(SIZE); k++) mem[k] = 32'h1000_0000 + 32'(k);
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    reset     = 1'b1;
    out_ready = 1'b1;

    // Stall with pc 8 at the head
    wait_head(32'd4, 20);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(out_valid && out_pc == 32'd8, "stall_head", out_pc, 32'd8);
      check(32'(imem_addr) == 32'd4, "stall_addr", 32'(imem_addr), 32'd4);
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check(out_pc == 32'd8 + 32'(4 * j), "resume_pc", out_pc, 32'd8 + 32'(4 * j));
      tick();
    end

    // Redirect to 0x40 with a full queue
    out_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    check(32'(imem_addr) == 32'd16, "redir40_addr", 32'(imem_addr), 32'd16);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    @(negedge clk);
    check(out_pc == 32'h40, "redir40_pc", out_pc, 32'h40);
    check(out_ins == mem[16], "redir40_ins", out_ins, mem[16]);
    tick();

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check(32'(imem_addr) == 32'd64, "misal_addr", 32'(imem_addr), 32'd64);
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    check(out_pc == 32'h100, "misal_pc", out_pc, 32'h100);
    tick();

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    check(out_pc == 32'h80, "b2b_pc", out_pc, 32'h80);
    tick();

    // Wrap of imem word index past 1023
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFF4;
    @(negedge clk);
    check(32'(imem_addr) == 32'd1021, "wrap_addr0", 32'(imem_addr), 32'd1021);
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check(32'(imem_addr) == wrap_addr[k], "wrap_addr", 32'(imem_addr), wrap_addr[k]);
      if (k == 3) check(out_pc == 32'hFFC, "wrap_pc_ffc", out_pc, 32'hFFC);
      if (k == 4) check(out_pc == 32'h1000 && out_ins == mem[0], "wrap_pc_1000",
                        out_pc, 32'h1000);
      tick();
    end

    // Asynchronous reset mid-stream with a full queue
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check(out_valid == 1'b0, "async_valid", 32'(out_valid), 32'd0);
    check(out_pc == 32'd0, "async_pc", out_pc, 32'd0);
    check(out_ins == 32'd0, "async_ins", out_ins, 32'd0);
    tick();
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    wait_head(RESET_PC, 6);
    repeat (6) tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        redirect_valid = 1'b0;
        reset          = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
